// File: rtl/fp_divider.sv
// IEEE-754 divider: reciprocal by Newton-Raphson on an external adder and
// combinational multiplier, then quotient = N * (1/D) with exponent repair.
module fp_divider #(
  parameter int unsigned PRECISION = 32,
  parameter int unsigned NR_ITER   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PRECISION-1:0] a_i,
  input  logic [PRECISION-1:0] b_i,
  input  logic                 load_i,
  input  logic                 enable_i,
  output logic [PRECISION-1:0] result_o,
  output logic                 valid_o,
  input  logic                 add_valid_i,
  input  logic [PRECISION-1:0] add_out_i,
  input  logic [PRECISION-1:0] mul_result_i,
  output logic [PRECISION-1:0] add_a_o,
  output logic [PRECISION-1:0] add_b_o,
  output logic                 add_op_o,
  output logic                 add_load_o,
  output logic [PRECISION-1:0] mul_a_o,
  output logic [PRECISION-1:0] mul_b_o
);

  localparam int unsigned EXP_W  = (PRECISION == 64) ? 11 : 8;
  localparam int unsigned FRAC_W = PRECISION - EXP_W - 1;
  localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned SE_W   = EXP_W + 2;
  localparam int unsigned IT_W   = (NR_ITER > 1) ? $clog2(NR_ITER) : 1;

  localparam logic [PRECISION-1:0] C_48_17 = (PRECISION == 64) ?
    PRECISION'(64'h4006969696969697) : PRECISION'(64'h4034B4B5);
  localparam logic [PRECISION-1:0] C_32_17 = (PRECISION == 64) ?
    PRECISION'(64'h3FFE1E1E1E1E1E1E) : PRECISION'(64'h3FF0F0F1);
  localparam logic [PRECISION-1:0] C_TWO = (PRECISION == 64) ?
    PRECISION'(64'h4000000000000000) : PRECISION'(64'h40000000);

  typedef enum logic [3:0] {
    S_IDLE, S_CLASSIFY, S_SEED_MUL, S_SEED_SUB, S_IT_MUL1,
    S_IT_SUB, S_IT_MUL2, S_Q_MUL, S_PACK, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PRECISION-1:0] a_q, b_q, t_q, t_d, x_q, x_d;
  logic [PRECISION-1:0] result_q, result_d, add_a_q, add_a_d, add_b_q, add_b_d;
  logic [PRECISION-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                 valid_q, valid_d, add_op_q, add_op_d, add_load_q, add_load_d;
  logic                 add_valid_prev_q;
  logic [IT_W-1:0]      iter_q, iter_d;

  logic start, add_done, last_iter;
  assign start     = load_i & enable_i;
  // Completion is a fresh AddValid rise seen strictly after the strobe cycle.
  assign add_done  = add_valid_i & ~add_valid_prev_q & ~add_load_q;
  assign last_iter = (iter_q == IT_W'(NR_ITER - 1));

  logic              a_sign, b_sign, t_sign;
  logic [EXP_W-1:0]  a_exp, b_exp, t_exp;
  logic [FRAC_W-1:0] a_frac, b_frac, t_frac;
  assign {a_sign, a_exp, a_frac} = a_q;
  assign {b_sign, b_exp, b_frac} = b_q;
  assign {t_sign, t_exp, t_frac} = t_q;

  // Subnormals count as zero; NaN/inf decoded from all-ones exponent.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, res_sign;
  assign a_zero   = (a_exp == '0);
  assign b_zero   = (b_exp == '0);
  assign a_inf    = (&a_exp) & (a_frac == '0);
  assign b_inf    = (&b_exp) & (b_frac == '0);
  assign a_nan    = (&a_exp) & (a_frac != '0);
  assign b_nan    = (&b_exp) & (b_frac != '0);
  assign special  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign res_sign = a_sign ^ b_sign;

  logic [PRECISION-1:0] inf_val, zero_val, qnan_val, special_val, packed_val, d_op, n_op;
  assign inf_val  = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign zero_val = {res_sign, {(PRECISION-1){1'b0}}};
  assign qnan_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  assign d_op     = {1'b0, EXP_W'(BIAS - 1), b_frac};
  assign n_op     = {1'b0, EXP_W'(BIAS - 1), a_frac};

  always_comb begin
    special_val = zero_val;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) special_val = qnan_val;
    else if (b_zero)                                          special_val = inf_val;
    else if (a_zero)                                          special_val = zero_val;
    else if (a_inf)                                           special_val = inf_val;
  end

  // Biased exponent of the quotient, two's complement in SE_W bits.
  logic [SE_W-1:0] q_exp;
  logic            q_ovf, q_unf;
  assign q_exp = SE_W'({2'b00, t_exp}) + SE_W'({2'b00, a_exp}) - SE_W'({2'b00, b_exp});
  assign q_unf = q_exp[SE_W-1] | (q_exp == '0);
  assign q_ovf = ~q_exp[SE_W-1] & (q_exp >= SE_W'({EXP_W{1'b1}}));
  assign packed_val = q_ovf ? inf_val : q_unf ? zero_val : {res_sign, q_exp[EXP_W-1:0], t_frac};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) state_d = S_CLASSIFY;
    else begin
      case (state_q)
        S_IDLE:     state_d = S_IDLE;
        S_CLASSIFY: state_d = special ? S_DONE : S_SEED_MUL;
        S_SEED_MUL: state_d = S_SEED_SUB;
        S_SEED_SUB: if (add_done) state_d = S_IT_MUL1;
        S_IT_MUL1:  state_d = S_IT_SUB;
        S_IT_SUB:   if (add_done) state_d = S_IT_MUL2;
        S_IT_MUL2:  state_d = last_iter ? S_Q_MUL : S_IT_MUL1;
        S_Q_MUL:    state_d = S_PACK;
        S_PACK:     state_d = S_DONE;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Captures results of the current state, then presents operands for the next.
  always_comb begin
    t_d        = t_q;
    x_d        = x_q;
    iter_d     = iter_q;
    mul_a_d    = '0;
    mul_b_d    = '0;
    add_a_d    = '0;
    add_b_d    = '0;
    add_op_d   = 1'b0;
    add_load_d = 1'b0;
    result_d   = result_q;
    valid_d    = valid_q & ~start;
    case (state_q)
      S_SEED_MUL, S_IT_MUL1, S_Q_MUL: t_d = mul_result_i;
      S_IT_MUL2:  x_d = mul_result_i;
      S_SEED_SUB: if (add_done) x_d = add_out_i;
      S_IT_SUB:   if (add_done) t_d = add_out_i;
      default:    t_d = t_q;
    endcase
    if (state_q == S_SEED_MUL) iter_d = '0;
    else if (state_q == S_IT_MUL2 && !last_iter) iter_d = iter_q + IT_W'(1);
    case (state_d)
      S_SEED_MUL: begin mul_a_d = C_32_17; mul_b_d = d_op; end
      S_SEED_SUB: begin
        add_a_d = C_48_17; add_b_d = t_d; add_op_d = 1'b1;
        add_load_d = (state_q != S_SEED_SUB);
      end
      S_IT_MUL1:  begin mul_a_d = d_op; mul_b_d = x_d; end
      S_IT_SUB:   begin
        add_a_d = C_TWO; add_b_d = t_d; add_op_d = 1'b1;
        add_load_d = (state_q != S_IT_SUB);
      end
      S_IT_MUL2:  begin mul_a_d = x_d; mul_b_d = t_d; end
      S_Q_MUL:    begin mul_a_d = n_op; mul_b_d = x_d; end
      S_DONE:     begin
        valid_d  = 1'b1;
        result_d = (state_q == S_CLASSIFY) ? special_val : packed_val;
      end
      default:    mul_a_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; t_q <= '0; x_q <= '0; iter_q <= '0;
      result_q <= '0; valid_q <= 1'b0;
      add_a_q <= '0; add_b_q <= '0; add_op_q <= 1'b0; add_load_q <= 1'b0;
      mul_a_q <= '0; mul_b_q <= '0; add_valid_prev_q <= 1'b0;
    end else begin
      if (start) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      t_q <= t_d; x_q <= x_d; iter_q <= iter_d;
      result_q <= result_d; valid_q <= valid_d;
      add_a_q <= add_a_d; add_b_q <= add_b_d; add_op_q <= add_op_d; add_load_q <= add_load_d;
      mul_a_q <= mul_a_d; mul_b_q <= mul_b_d; add_valid_prev_q <= add_valid_i;
    end
  end

  assign result_o   = result_q;
  assign valid_o    = valid_q;
  assign add_a_o    = add_a_q;
  assign add_b_o    = add_b_q;
  assign add_op_o   = add_op_q;
  assign add_load_o = add_load_q;
  assign mul_a_o    = mul_a_q;
  assign mul_b_o    = mul_b_q;

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider with a 25 ns adder model and an exact-rounding
// combinational multiplier model.
module tb_fp_divider;

  logic        clk, rst_n, load, enable, add_valid, add_op, add_load;
  logic [31:0] a_in, b_in, result, add_out, mul_result, add_a, add_b, mul_a, mul_b;
  logic        valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_add_loads = 0;
  int unsigned n_mul_active = 0;
  int unsigned add_cnt = 0;
  logic [31:0] add_pend;

  fp_divider dut (
    .clk(clk), .rst_n(rst_n), .a_i(a_in), .b_i(b_in), .load_i(load), .enable_i(enable),
    .result_o(result), .valid_o(valid), .add_valid_i(add_valid), .add_out_i(add_out),
    .mul_result_i(mul_result), .add_a_o(add_a), .add_b_o(add_b), .add_op_o(add_op),
    .add_load_o(add_load), .mul_a_o(mul_a), .mul_b_o(mul_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else                        d = {f[31], 11'({3'd0, f[30:23]} + 11'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round a double to nearest-even single precision.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(r);
    e = int'({21'd0, d[62:52]}) - 896;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, |d[51:0], 22'd0};
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  assign mul_result = r2f(f2r(mul_a) * f2r(mul_b));

  // Adder model: AddValid drops on a sampled AddLoad, result appears 25 ns later.
  always @(clk) begin
    if (clk && add_load) begin
      n_add_loads = n_add_loads + 1;
      add_pend = r2f(add_op ? f2r(add_a) - f2r(add_b) : f2r(add_a) + f2r(add_b));
      add_cnt = 5;
      add_valid <= 1'b0;
    end else if (add_cnt > 0) begin
      add_cnt = add_cnt - 1;
      if (add_cnt == 0) begin
        add_out   <= add_pend;
        add_valid <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (mul_a != 32'd0 || mul_b != 32'd0) n_mul_active = n_mul_active + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp,
                       input int unsigned tol);
    logic [63:0] diff;
    n_checks = n_checks + 1;
    diff = (got > exp) ? got - exp : exp - got;
    if (diff > 64'(tol)) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_in = a; b_in = b; load = 1'b1; enable = 1'b1;
    @(negedge clk);
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc);
    start_op(a, b);
    cyc = 0;
    while (!valid && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
    if (!valid) check("valid_timeout", 64'(valid), 64'd1, 0);
    res = result;
  endtask

  logic [31:0] res;
  int          cyc;
  int unsigned loads0, mul0;

  initial begin
    rst_n = 1'b0; load = 1'b0; enable = 1'b0; a_in = '0; b_in = '0;
    add_valid = 1'b0; add_out = '0; add_pend = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'd0, 0);
    check("rst_ctrl", 64'({valid, add_load, add_op}), 64'd0, 0);
    check("rst_add_ops", 64'(add_a | add_b), 64'd0, 0);
    check("rst_mul_ops", 64'(mul_a | mul_b), 64'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.5 / 1.5 : seed plus three iterations use the adder four times
    loads0 = n_add_loads;
    run_op(32'h3FC00000, 32'h3FC00000, res, cyc);
    check("q_1p5_1p5", 64'(res), 64'h3F800000, 2);
    check("adds_1p5", 64'(n_add_loads - loads0), 64'd4, 0);
    repeat (3) @(negedge clk);
    check("valid_hold", 64'(valid), 64'd1, 0);
    check("result_hold", 64'(result), 64'h3F800000, 2);

    run_op(32'h4048F5C3, 32'h3CA3D70A, res, cyc);
    check("q_314_002", 64'(res), 64'(r2f(f2r(32'h4048F5C3) / f2r(32'h3CA3D70A))), 2);
    check("q_157_band", 64'(res), 64'h431D0000, 4);
    run_op(32'h3CA3D70A, 32'h4048F5C3, res, cyc);
    check("q_002_314", 64'(res), 64'(r2f(f2r(32'h3CA3D70A) / f2r(32'h4048F5C3))), 2);
    run_op(32'hC0E00000, 32'h40000000, res, cyc);
    check("q_m7_2", 64'(res), 64'hC0600000, 2);

    // Zero dividend: immediate result, no arithmetic traffic
    loads0 = n_add_loads; mul0 = n_mul_active;
    run_op(32'h00000000, 32'h4048F5C3, res, cyc);
    check("q_0_314", 64'(res), 64'h00000000, 0);
    check("lat_special", 64'(cyc), 64'd1, 0);
    check("adds_special", 64'(n_add_loads - loads0), 64'd0, 0);
    check("muls_special", 64'(n_mul_active - mul0), 64'd0, 0);

    run_op(32'h00000000, 32'h00000000, res, cyc); check("q_0_0", 64'(res), 64'h7FC00000, 0);
    run_op(32'hBF800000, 32'h00000000, res, cyc); check("q_m1_0", 64'(res), 64'hFF800000, 0);
    run_op(32'h7F800000, 32'h40000000, res, cyc); check("q_inf_2", 64'(res), 64'h7F800000, 0);
    run_op(32'hC0000000, 32'h7F800000, res, cyc); check("q_m2_inf", 64'(res), 64'h80000000, 0);
    run_op(32'hFF800000, 32'hFF800000, res, cyc); check("q_inf_inf", 64'(res), 64'h7FC00000, 0);
    run_op(32'h3F800000, 32'hFFC00000, res, cyc); check("q_1_nan", 64'(res), 64'h7FC00000, 0);
    run_op(32'h00000001, 32'h40000000, res, cyc); check("q_sub_2", 64'(res), 64'h00000000, 0);
    run_op(32'h3F800000, 32'h00000000, res, cyc); check("q_1_0", 64'(res), 64'h7F800000, 0);

    // Load without Enable must not disturb the held result
    @(negedge clk);
    a_in = 32'h3FC00000; b_in = 32'h3FC00000; load = 1'b1; enable = 1'b0;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("noenable_valid", 64'(valid), 64'd1, 0);
    check("noenable_result", 64'(result), 64'h7F800000, 0);

    // Exponent range limits on the normal path
    run_op(32'h7F000000, 32'h3E800000, res, cyc); check("q_overflow", 64'(res), 64'h7F800000, 0);
    run_op(32'h80800000, 32'h40000000, res, cyc); check("q_underflow", 64'(res), 64'h80000000, 0);

    // Restart while busy
    start_op(32'h4048F5C3, 32'h3CA3D70A);
    repeat (3) @(negedge clk);
    run_op(32'hC0400000, 32'h3FC00000, res, cyc);
    check("q_restart", 64'(res), 64'hC0000000, 2);

    // Reset while the adder is outstanding
    start_op(32'h3FC00000, 32'h3FC00000);
    cyc = 0;
    while (!add_load && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
    check("saw_addload", 64'(add_load), 64'd1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", 64'(result), 64'd0, 0);
    check("midrst_ctrl", 64'({valid, add_load, add_op}), 64'd0, 0);
    check("midrst_add_ops", 64'(add_a | add_b), 64'd0, 0);
    check("midrst_mul_ops", 64'(mul_a | mul_b), 64'd0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    loads0 = n_add_loads;
    run_op(32'h3FC00000, 32'h3FC00000, res, cyc);
    check("q_after_rst", 64'(res), 64'h3F800000, 2);
    check("adds_after_rst", 64'(n_add_loads - loads0), 64'd4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 Parameter PRECISION, default 32, operand width; 32 selects 8-bit exponent/23-bit fraction, 64 selects 11/52; other values unsupported.
REQ-002 Parameter NR_ITER, default 3, number of Newton-Raphson refinement iterations.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  in  1  asynchronous, active-low reset.
REQ-005 A  in  PRECISION  IEEE-754 dividend.
REQ-006 B  in  PRECISION  IEEE-754 divisor.
REQ-007 Load  in  1  start request, sampled at rising Clk.
REQ-008 Enable  in  1  operation-select qualifier; Load is ignored unless Enable=1.
REQ-009 Result  out  PRECISION  quotient A/B.
REQ-010 Valid  out  1  Result holds a completed quotient.
REQ-011 AddValid  in  1  external adder result-ready level.
REQ-012 AddOut  in  PRECISION  external adder result.
REQ-013 MulResult  in  PRECISION  external combinational multiplier product of MulA*MulB.
REQ-014 AddA, AddB  out  PRECISION each  adder operands.
REQ-015 AddOp  out  1  0 = AddA+AddB, 1 = AddA-AddB.
REQ-016 AddLoad  out  1  adder start strobe.
REQ-017 MulA, MulB  out  PRECISION each  multiplier operands.

Function
REQ-018 Start: Load=1 and Enable=1 at a rising edge registers A and B, clears Valid, enters classification; a start while busy aborts and restarts.
REQ-019 Special cases, resolved in the cycle after start with no adder/multiplier traffic: B=0,A=0 or either NaN -> quiet NaN (exp all ones, MSB of fraction 1); B=0,A!=0 -> infinity; A=0 -> zero; A=inf,B finite -> inf; B=inf,A finite -> zero; inf/inf -> NaN; sign = sign(A) XOR sign(B) except NaN (sign 0).
REQ-020 Subnormal inputs are flushed to signed zero before classification.
REQ-021 Normal path: D = |B| fraction with exponent forced to bias-1 (D in [0.5,1)); N = |A| fraction with exponent forced to bias-1.
REQ-022 Seed: X0 = 48/17 - (32/17)*D, computed as one multiply then one adder subtract.
REQ-023 Each iteration: T = D*X (multiply), T = 2 - T (adder, AddOp=1), X = X*T (multiply); NR_ITER iterations.
REQ-024 Quotient: Q = N*X (multiply); Result exponent = exp(Q) + exp(A) - exp(B); sign per REQ-019.
REQ-025 Final exponent >= all-ones -> signed infinity; <= 0 -> signed zero (no subnormal outputs).
REQ-026 State machine: IDLE -> CLASSIFY -> {DONE | SEED_MUL -> SEED_SUB -> IT_MUL1 -> IT_SUB -> IT_MUL2 -> (IT_MUL1 | Q_MUL) -> PACK -> DONE}; DONE -> IDLE.
REQ-027 Multiply states: drive MulA/MulB for one cycle, capture MulResult at the next rising edge; MulA/MulB = 0 outside multiply states.
REQ-028 Adder handshake: AddA/AddB/AddOp registered and AddLoad=1 for exactly one cycle; operands held stable until completion; completion = AddValid rising edge (registered previous AddValid 0, current 1) detected after the strobe; AddOut captured that edge.
REQ-029 Adder latency is unbounded; unit waits indefinitely; AddLoad=0, AddA/AddB/AddOp=0 when idle.
REQ-030 DONE: Result registered, Valid=1; Valid and Result held until next start.
REQ-031 Accuracy: normal-path Result within 2 ulp of correctly rounded A/B.

Reset
REQ-032 Rst_n=0 asynchronously forces IDLE; Result=0, Valid=0, AddLoad=0, AddA=AddB=0, AddOp=0, MulA=MulB=0, operand registers cleared.
REQ-033 Reset mid-operation abandons the computation; a late AddValid edge after reset is ignored.

Verification (10 ns clock, adder model: AddValid drops at AddLoad, result + AddValid=1 after 25 ns)
REQ-034 A=1.5,B=1.5, Load one cycle -> Valid rises, Result=1.0 (0x3F800000) within 2 ulp; 4 adder requests (seed + 3 iterations).
REQ-035 A=3.14,B=0.02 -> Result~157.0 within 2 ulp; A=0.02,B=3.14 -> Result~0.0063694 within 2 ulp.
REQ-036 A=0.0,B=3.14 -> Result=0x00000000, Valid one cycle after CLASSIFY, zero AddLoad pulses, MulA=MulB=0 throughout.
REQ-037 A=0.0,B=0.0 -> quiet NaN 0x7FC00000; A=1.0,B=0.0 -> 0x7F800000; A=-1.0,B=0.0 -> 0xFF800000.
REQ-038 Rst_n low while waiting on adder -> all outputs zero immediately; subsequent 1.5/1.5 start completes correctly.
